// File: rtl/sa_cache_ctrl_pkg.sv
// Shared types, constants and address helpers for the 2-way set-associative cache controller.
// Set layout: two ways of {valid, dirty, tag, line} plus one lru bit naming the next victim.
// Optional feature macro used by the controller: SA_CACHE_STATS_EN (hit/miss counters).
package sa_cache_ctrl_pkg;

  localparam int unsigned INDEX_W  = 10;
  localparam int unsigned OFFSET_W = 4;
  localparam int unsigned TAG_W    = 32 - INDEX_W - OFFSET_W;
  localparam int unsigned LINE_W   = 128;
  localparam int unsigned WORD_W   = 32;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StTagCheck,
    StWriteBack,
    StAllocate,
    StRefill,
    StReread
  } cache_state_e;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] line;
  } cache_way_type;

  typedef struct packed {
    cache_way_type [1:0] way;
    logic                lru;
  } cache_data_type;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               we;
  } cache_index_type;

  function automatic logic [TAG_W-1:0] get_tag(input logic [31:0] addr);
    return addr[31 -: TAG_W];
  endfunction

  function automatic logic [INDEX_W-1:0] get_index(input logic [31:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  function automatic logic [1:0] get_word(input logic [31:0] addr);
    return addr[3:2];
  endfunction

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        sel);
    return line[WORD_W*int'(sel) +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        sel,
                                                   input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] res;
    res = line;
    res[WORD_W*int'(sel) +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/sa_cache_ctrl_if.sv
// CPU-side and next-level-memory-side handshake bundle for sa_cache_ctrl.
//   slave  : the controller (accepts CPU requests, issues memory requests)
//   master : the environment (CPU issuing requests, memory answering them)
// Signals: cpu_req_{valid,ready,rw,addr,wdata}, cpu_res_{valid,rdata},
//          mem_req_{valid,rw,addr,wdata}, mem_res_{ready,rdata}.
interface sa_cache_ctrl_if
  import sa_cache_ctrl_pkg::*;
();

  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic              cpu_req_rw;
  logic [31:0]       cpu_req_addr;
  logic [31:0]       cpu_req_wdata;
  logic              cpu_res_valid;
  logic [31:0]       cpu_res_rdata;

  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [31:0]       mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_res_ready;
  logic [LINE_W-1:0] mem_res_rdata;

  modport slave (
    input  cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_wdata,
    input  mem_res_ready, mem_res_rdata,
    output cpu_req_ready, cpu_res_valid, cpu_res_rdata,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata
  );

  modport master (
    output cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_wdata,
    output mem_res_ready, mem_res_rdata,
    input  cpu_req_ready, cpu_res_valid, cpu_res_rdata,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata
  );

endinterface

// File: rtl/sa_cache_ctrl_tag_cmp.sv
// Combinational tag compare for one 2-way set.
//   set_i        : set read from the cache array
//   tag_i        : request tag
//   hit_o        : some valid way holds tag_i
//   hit_way_o    : which way hit (meaningful only with hit_o)
//   victim_way_o : way to replace on a miss (the set's lru bit)
module sa_cache_tag_cmp
  import sa_cache_ctrl_pkg::*;
(
  input  cache_data_type   set_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             hit_o,
  output logic             hit_way_o,
  output logic             victim_way_o
);

  logic [1:0] way_hit;

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      way_hit[w] = set_i.way[w].valid && (set_i.way[w].tag == tag_i);
    end
    hit_o        = |way_hit;
    hit_way_o    = way_hit[1];
    victim_way_o = set_i.lru;
  end

  logic unused_set;
  assign unused_set = ^{set_i.way[0].dirty, set_i.way[1].dirty,
                        set_i.way[0].line, set_i.way[1].line};

endmodule

// File: rtl/sa_cache_ctrl.sv
// Controller FSM for the 2-way set-associative cache; sole driver of sa_cache_mem.
// Clears the array after reset, then serves CPU word requests with tag compare,
// dirty write-back and line refill from the next-level memory.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   bus (slave)       : CPU request/response and next-level memory handshakes (registered outputs)
//   cache_index       : {index, we} to sa_cache_mem (combinational)
//   cache_data_write  : set written to sa_cache_mem (combinational)
//   cache_data_read   : set read from sa_cache_mem (one-cycle latency, reads when we=0)
//   hit_count, miss_count : only when SA_CACHE_STATS_EN is defined; saturating counters of
//                           tag checks entered from IDLE
module sa_cache_ctrl
  import sa_cache_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  sa_cache_ctrl_if.slave  bus,
  output cache_index_type cache_index,
  output cache_data_type  cache_data_write,
  input  cache_data_type  cache_data_read
`ifdef SA_CACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  cache_state_e       state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;

  logic               req_rw_q, req_rw_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic [INDEX_W-1:0] req_index_q, req_index_d;
  logic [1:0]         req_word_q, req_word_d;
  logic [31:0]        req_wdata_q, req_wdata_d;
  logic               victim_q, victim_d;
  logic [LINE_W-1:0]  fill_line_q, fill_line_d;

  logic               ready_q, ready_d;
  logic               res_valid_q, res_valid_d;
  logic [31:0]        res_rdata_q, res_rdata_d;
  logic               mreq_valid_q, mreq_valid_d;
  logic               mreq_rw_q, mreq_rw_d;
  logic [31:0]        mreq_addr_q, mreq_addr_d;
  logic [LINE_W-1:0]  mreq_wdata_q, mreq_wdata_d;

  logic               hit, hit_way, victim_way;
  logic               accept;
  logic [LINE_W-1:0]  hit_line;
  cache_way_type      victim;

  sa_cache_tag_cmp u_tag_cmp (
    .set_i        (cache_data_read),
    .tag_i        (req_tag_q),
    .hit_o        (hit),
    .hit_way_o    (hit_way),
    .victim_way_o (victim_way)
  );

  assign accept = (state_q == StIdle) && bus.cpu_req_valid && ready_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_rw_d     = req_rw_q;
    req_tag_d    = req_tag_q;
    req_index_d  = req_index_q;
    req_word_d   = req_word_q;
    req_wdata_d  = req_wdata_q;
    victim_d     = victim_q;
    fill_line_d  = fill_line_q;
    ready_d      = ready_q;
    res_valid_d  = 1'b0;
    res_rdata_d  = res_rdata_q;
    mreq_valid_d = mreq_valid_q;
    mreq_rw_d    = mreq_rw_q;
    mreq_addr_d  = mreq_addr_q;
    mreq_wdata_d = mreq_wdata_q;

    cache_index.index = req_index_q;
    cache_index.we    = 1'b0;
    cache_data_write  = cache_data_read;
    hit_line          = cache_data_read.way[hit_way].line;
    victim            = cache_data_read.way[victim_way];

    unique case (state_q)
      StInit: begin
        cache_index.index = cnt_q;
        cache_index.we    = 1'b1;
        cache_data_write  = '0;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end
      end

      StIdle: begin
        // Present the incoming index so the set is ready during TAG_CHECK.
        cache_index.index = get_index(bus.cpu_req_addr);
        if (accept) begin
          req_rw_d    = bus.cpu_req_rw;
          req_tag_d   = get_tag(bus.cpu_req_addr);
          req_index_d = get_index(bus.cpu_req_addr);
          req_word_d  = get_word(bus.cpu_req_addr);
          req_wdata_d = bus.cpu_req_wdata;
          ready_d     = 1'b0;
          state_d     = StTagCheck;
        end
      end

      StTagCheck: begin
        if (hit) begin
          if (req_rw_q) begin
            hit_line = merge_word(hit_line, req_word_q, req_wdata_q);
            cache_data_write.way[hit_way].dirty = 1'b1;
          end
          cache_data_write.way[hit_way].line = hit_line;
          cache_data_write.lru = ~hit_way;
          cache_index.we       = 1'b1;
          res_valid_d          = 1'b1;
          res_rdata_d          = line_word(hit_line, req_word_q);
          ready_d              = 1'b1;
          state_d              = StIdle;
        end else begin
          victim_d     = victim_way;
          mreq_valid_d = 1'b1;
          if (victim.valid && victim.dirty) begin
            mreq_rw_d    = 1'b1;
            mreq_addr_d  = {victim.tag, req_index_q, 4'b0};
            mreq_wdata_d = victim.line;
            state_d      = StWriteBack;
          end else begin
            mreq_rw_d   = 1'b0;
            mreq_addr_d = {req_tag_q, req_index_q, 4'b0};
            state_d     = StAllocate;
          end
        end
      end

      StWriteBack: begin
        if (bus.mem_res_ready) begin
          mreq_rw_d   = 1'b0;
          mreq_addr_d = {req_tag_q, req_index_q, 4'b0};
          state_d     = StAllocate;
        end
      end

      StAllocate: begin
        if (bus.mem_res_ready) begin
          fill_line_d  = bus.mem_res_rdata;
          mreq_valid_d = 1'b0;
          state_d      = StRefill;
        end
      end

      StRefill: begin
        // cache_data_read still holds this set: the array kept reading it while we=0.
        cache_index.we = 1'b1;
        cache_data_write.way[victim_q].valid = 1'b1;
        cache_data_write.way[victim_q].dirty = 1'b0;
        cache_data_write.way[victim_q].tag   = req_tag_q;
        cache_data_write.way[victim_q].line  = fill_line_q;
        state_d = StReread;
      end

      StReread: begin
        state_d = StTagCheck;
      end

      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StInit;
      cnt_q        <= '0;
      req_rw_q     <= 1'b0;
      req_tag_q    <= '0;
      req_index_q  <= '0;
      req_word_q   <= '0;
      req_wdata_q  <= '0;
      victim_q     <= 1'b0;
      fill_line_q  <= '0;
      ready_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_rdata_q  <= '0;
      mreq_valid_q <= 1'b0;
      mreq_rw_q    <= 1'b0;
      mreq_addr_q  <= '0;
      mreq_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_rw_q     <= req_rw_d;
      req_tag_q    <= req_tag_d;
      req_index_q  <= req_index_d;
      req_word_q   <= req_word_d;
      req_wdata_q  <= req_wdata_d;
      victim_q     <= victim_d;
      fill_line_q  <= fill_line_d;
      ready_q      <= ready_d;
      res_valid_q  <= res_valid_d;
      res_rdata_q  <= res_rdata_d;
      mreq_valid_q <= mreq_valid_d;
      mreq_rw_q    <= mreq_rw_d;
      mreq_addr_q  <= mreq_addr_d;
      mreq_wdata_q <= mreq_wdata_d;
    end
  end

  assign bus.cpu_req_ready = ready_q;
  assign bus.cpu_res_valid = res_valid_q;
  assign bus.cpu_res_rdata = res_rdata_q;
  assign bus.mem_req_valid = mreq_valid_q;
  assign bus.mem_req_rw    = mreq_rw_q;
  assign bus.mem_req_addr  = mreq_addr_q;
  assign bus.mem_req_wdata = mreq_wdata_q;

`ifdef SA_CACHE_STATS_EN
  // Only checks that start from IDLE count; the REREAD-driven recheck is skipped.
  logic        from_idle_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      from_idle_q <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      from_idle_q <= accept;
      if (state_q == StTagCheck && from_idle_q) begin
        if (hit && hit_cnt_q != '1) begin
          hit_cnt_q <= hit_cnt_q + 1'b1;
        end else if (!hit && miss_cnt_q != '1) begin
          miss_cnt_q <= miss_cnt_q + 1'b1;
        end
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  logic unused_addr;
  assign unused_addr = ^bus.cpu_req_addr[1:0];

endmodule

// File: tb/tb_sa_cache_ctrl.sv
module tb_sa_cache_ctrl;
  import sa_cache_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  sa_cache_ctrl_if bus ();
  cache_index_type cache_index;
  cache_data_type  cache_data_write;
  cache_data_type  rd_q;
  cache_data_type  mem_arr [0:1023];
`ifdef SA_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  sa_cache_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .cache_index      (cache_index),
    .cache_data_write (cache_data_write),
    .cache_data_read  (rd_q)
`ifdef SA_CACHE_STATS_EN
    ,
    .hit_count        (hit_count),
    .miss_count       (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Array model: one-cycle read latency, reads only while we=0.
  always @(posedge clk) begin
    if (cache_index.we) mem_arr[cache_index.index] <= cache_data_write;
    else                rd_q <= mem_arr[cache_index.index];
  end

  localparam logic [127:0] L1  = 128'h03030303_02020202_A5A5A5A5_01010101;
  localparam logic [127:0] L1D = 128'h03030303_02020202_DEADBEEF_01010101;
  localparam logic [127:0] L2  = 128'h13131313_12121212_5A5A5A5A_11111111;
  localparam logic [127:0] L3  = 128'h23232323_22222222_99999999_21212121;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with ready high; returns at the negedge after acceptance.
  task automatic send(input logic rw, input logic [31:0] addr, input logic [31:0] wd);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_rw    = rw;
    bus.cpu_req_addr  = addr;
    bus.cpu_req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (bus.cpu_res_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_res_timeout"}, bus.cpu_res_valid, 1'b1);
  endtask

  task automatic wait_mreq(input string tag);
    int n = 0;
    while (bus.mem_req_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_mreq_timeout"}, bus.mem_req_valid, 1'b1);
  endtask

  task automatic mem_respond(input logic [127:0] line);
    bus.mem_res_ready = 1'b1;
    bus.mem_res_rdata = line;
    @(negedge clk);
    bus.mem_res_ready = 1'b0;
    bus.mem_res_rdata = '0;
  endtask

  initial begin
    int bad;
    rst_n             = 1'b0;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_rw    = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_wdata = '0;
    bus.mem_res_ready = 1'b0;
    bus.mem_res_rdata = '0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.cpu_req_ready, 1'b0);
    chk("rst_res_valid", bus.cpu_res_valid, 1'b0);
    chk("rst_rdata", bus.cpu_res_rdata, 32'h0);
    chk("rst_mreq", {bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr}, 34'h0);
    chk("rst_mwdata", bus.mem_req_wdata, 128'h0);
    rst_n = 1'b1;

    // INIT sweep: indices 0..1023 in order with we=1 and zero data, ready still low
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (cache_index !== {i[9:0], 1'b1} || cache_data_write !== '0 ||
          bus.cpu_req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("init_sweep_bad", bad, 0);
    chk("ready_cycle_1025", bus.cpu_req_ready, 1'b1);

    // Clean read miss
    bus.cpu_req_addr = 32'h0000_1234;
    #1;
    chk("idle_index", cache_index, {10'h123, 1'b0});
    send(1'b0, 32'h0000_1234, 32'h0);
    chk("miss_ready_low", bus.cpu_req_ready, 1'b0);
    wait_mreq("miss1");
    chk("miss1_rw", bus.mem_req_rw, 1'b0);
    chk("miss1_addr", bus.mem_req_addr, 32'h0000_1230);
    mem_respond(L1);
    chk("refill_mreq_low", bus.mem_req_valid, 1'b0);
    chk("refill_index", cache_index, {10'h123, 1'b1});
    chk("refill_way0", cache_data_write.way[0], {1'b1, 1'b0, 18'h0, L1});
    wait_res("miss1");
    chk("miss1_rdata", bus.cpu_res_rdata, 32'hA5A5A5A5);

    // Read hit: response two cycles after acceptance, no memory traffic
    send(1'b0, 32'h0000_1234, 32'h0);
    chk("hit_res_early", bus.cpu_res_valid, 1'b0);
    chk("hit_lru", {cache_index.we, cache_data_write.lru}, 2'b11);
    @(negedge clk);
    chk("hit_res_valid", bus.cpu_res_valid, 1'b1);
    chk("hit_rdata", bus.cpu_res_rdata, 32'hA5A5A5A5);
    chk("hit_no_mreq", bus.mem_req_valid, 1'b0);

    // Stray mem_res_ready in IDLE is ignored
    mem_respond(L3);
    chk("stray_mres", {bus.mem_req_valid, bus.cpu_req_ready, bus.cpu_res_valid}, 3'b010);

    // Write hit to way0
    send(1'b1, 32'h0000_1234, 32'hDEADBEEF);
    chk("whit_we", cache_index, {10'h123, 1'b1});
    chk("whit_way0", cache_data_write.way[0], {1'b1, 1'b1, 18'h0, L1D});
    chk("whit_lru", cache_data_write.lru, 1'b1);
    wait_res("whit");

    // Read 0x5234 fills way1
    send(1'b0, 32'h0000_5234, 32'h0);
    wait_mreq("miss2");
    chk("miss2_req", {bus.mem_req_rw, bus.mem_req_addr}, {1'b0, 32'h0000_5230});
    mem_respond(L2);
    chk("miss2_refill_way1", cache_data_write.way[1], {1'b1, 1'b0, 18'h1, L2});
    wait_res("miss2");
    chk("miss2_rdata", bus.cpu_res_rdata, 32'h5A5A5A5A);

    // Read 0x9234 evicts dirty way0, with a 20-cycle memory stall
    send(1'b0, 32'h0000_9234, 32'h0);
    wait_mreq("wb");
    chk("wb_rw", bus.mem_req_rw, 1'b1);
    chk("wb_addr", bus.mem_req_addr, 32'h0000_1230);
    chk("wb_wdata", bus.mem_req_wdata, L1D);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_rw !== 1'b1 ||
          bus.mem_req_addr !== 32'h0000_1230 || bus.mem_req_wdata !== L1D) bad++;
    end
    chk("wb_stall_bad", bad, 0);
    mem_respond(128'h0);
    chk("alloc_after_wb", {bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr},
        {1'b1, 1'b0, 32'h0000_9230});
    mem_respond(L3);
    wait_res("miss3");
    chk("miss3_rdata", bus.cpu_res_rdata, 32'h99999999);

    // Make way1 dirty, touch way0, then miss so the write-back targets way1
    send(1'b1, 32'h0000_5234, 32'h11112222);
    wait_res("whit2");
    send(1'b0, 32'h0000_9234, 32'h0);
    wait_res("hit3");
    chk("hit3_rdata", bus.cpu_res_rdata, 32'h99999999);
    send(1'b0, 32'h0000_D234, 32'h0);
    wait_mreq("wb2");
    chk("wb2_req", {bus.mem_req_rw, bus.mem_req_addr}, {1'b1, 32'h0000_5230});
`ifdef SA_CACHE_STATS_EN
    chk("stats_hits", hit_count, 32'd4);
    chk("stats_misses", miss_count, 32'd4);
`endif

    // Reset during WRITE_BACK
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstwb_mreq", bus.mem_req_valid, 1'b0);
    chk("rstwb_ready", bus.cpu_req_ready, 1'b0);
    chk("rstwb_index", cache_index, {10'h000, 1'b1});
`ifdef SA_CACHE_STATS_EN
    chk("stats_rst", {hit_count, miss_count}, 64'h0);
`endif
    rst_n = 1'b1;
    #1;
    chk("reinit_idx0", cache_index, {10'h000, 1'b1});
    @(negedge clk);
    chk("reinit_idx1", cache_index, {10'h001, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
